// File: rtl/rx_block_if.sv
// Serial-in / byte-out bundle of the UART receiver: oversampling strobe and line in,
// received byte plus its completion and framing-error pulses out.
interface rx_block_if;
  logic       clk_en;
  logic       rx_in;
  logic [7:0] mdata;
  logic       done;
  logic       frame_err;

  modport master (output clk_en, output rx_in, input mdata, input done, input frame_err);
  modport slave  (input clk_en, input rx_in, output mdata, output done, output frame_err);
endinterface

// File: rtl/rx_block.sv
// 8N1 UART receiver. Bit timing is taken from an OVERSAMPLE x baud strobe, and each bit
// is sampled mid-cell. Good frames pulse done; a low stop bit pulses frame_err.
module rx_block #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  rx_block_if.slave   rx_if
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    mdata_q, mdata_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q;
  logic          rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_if.rx_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Every state change also clears cnt so each phase counts from its own entry tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    if (rx_if.clk_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            bidx_d  = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            sh_d   = {rx_s, sh_q[7:1]};
            cnt_d  = '0;
            bidx_d = bidx_q + 1'b1;
            if (bidx_q == BIT_LAST) state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_BRK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BRK: begin
          if (rx_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    mdata_d = mdata_q;
    if (rx_if.clk_en && state_q == S_STOP && cnt_q == CNT_LAST) begin
      if (rx_s) begin
        done_d  = 1'b1;
        mdata_d = sh_q;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign rx_if.mdata     = mdata_q;
  assign rx_if.done      = done_q;
  assign rx_if.frame_err = ferr_q;
endmodule

// File: tb/tb_rx_block.sv
// Directed bench for the UART receiver: a driver serialises frames tick by tick and
// queues the expected pulse; an independent monitor pops and compares on each pulse.
module tb_rx_block;
  localparam int OS = 16;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         tick;
  } exp_t;

  logic clk;
  logic rst_n;
  rx_block_if bus ();

  rx_block #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus)
  );

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ticks  = 0;
  logic [7:0] exp_mdata = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clk_en: one cycle in four; ticks numbers the pulses issued so far.
  initial begin
    int phase;
    phase = 0;
    bus.clk_en = 1'b0;
    forever begin
      @(negedge clk);
      bus.clk_en = (phase == 3);
      if (bus.clk_en) ticks++;
      phase = (phase + 1) % 4;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.clk_en) @(posedge clk);
    end
    #1;
  endtask

  task automatic drained(input string name);
    chk(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // DUT tick 0 is the first pulse after the line drops (sync delay < one tick period).
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err  = ~stop;
    e.data = stop ? d : exp_mdata;
    e.tick = ticks + 1 + OS/2 + 9*OS;
    sb_q.push_back(e);
    if (stop) exp_mdata = d;
    bus.rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      wait_ticks(OS);
    end
    bus.rx_in = stop;
    wait_ticks(OS);
  endtask

  // Monitor
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.done || bus.frame_err) begin
        chk("pulse_width", int'(prev), 0);
        chk("pulse_exclusive", int'(bus.done && bus.frame_err), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", int'(bus.frame_err) * 256 + int'(bus.mdata), -1);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_kind_ferr", int'(bus.frame_err), int'(e.err));
          chk("mdata", int'(bus.mdata), int'(e.data));
          chk("pulse_tick", ticks, e.tick);
        end
      end
      prev = bus.done | bus.frame_err;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_mdata", int'(bus.mdata), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_ferr", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    wait_ticks(200);
    chk("idle_mdata", int'(bus.mdata), 0);
    drained("idle_no_pulse");

    send_frame(8'hA5, 1'b1);
    wait_ticks(10);
    drained("single_A5");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_ticks(10);
    drained("b2b_three");

    bus.rx_in = 1'b0;
    wait_ticks(4);
    bus.rx_in = 1'b1;
    wait_ticks(30);
    drained("glitch_rejected");
    send_frame(8'h5A, 1'b1);
    wait_ticks(10);
    drained("after_glitch_5A");

    send_frame(8'h81, 1'b0);
    wait_ticks(40);
    drained("ferr_and_break");
    bus.rx_in = 1'b1;
    wait_ticks(4);
    send_frame(8'h42, 1'b1);
    wait_ticks(10);
    drained("after_break_42");

    // Start and four data bits of C3, then reset mid-frame.
    bus.rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = ((8'hC3 >> i) & 8'h01) != 0;
      wait_ticks(OS);
    end
    rst_n = 1'b0;
    bus.rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_mdata", int'(bus.mdata), 0);
    exp_mdata = 8'h00;
    rst_n = 1'b1;
    wait_ticks(200);
    drained("midreset_no_pulse");
    chk("post_reset_mdata", int'(bus.mdata), 0);
    send_frame(8'h17, 1'b1);
    wait_ticks(10);
    drained("after_reset_17");
    chk("final_mdata", int'(bus.mdata), 8'h17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
